// File: rtl/monitor_dbg_data_in.sv
// Monitor debug input PIO: synchronizes and debounces an asynchronous debug bus,
// latches qualified edges into a W1C capture register and raises a maskable irq.

module monitor_dbg_data_in_lane #(
    parameter int DEBOUNCE = 4,
    parameter int CW       = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic prime_load,
    input  logic primed,
    input  logic s_bit,
    output logic f_bit,
    output logic upd
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronized bit disagrees with the
    // filtered bit, so any agreement restarts the stability window.
    always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        upd   = 1'b0;
        if (prime_load) begin
            f_d   = s_bit;
            cnt_d = '0;
        end else if (primed) begin
            if (s_bit == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                f_d   = s_bit;
                cnt_d = '0;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign f_bit = f_q;

endmodule

module monitor_dbg_data_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
    logic             primed_q, primed_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sdata, fdata, upd, ev, wmask, w1c;
    logic             prime_load, rd_en, wr_en;
    logic             unused_wd;

    assign sdata     = sync_q[SYNC_STAGES-1];
    assign wmask     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign rd_en     = chipselect & ~read_n;
    assign wr_en     = chipselect & ~write_n;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    end

    // Priming waits until the synchronizer holds post-reset samples, then loads
    // fdata directly so inputs already high at reset never look like edges.
    always_comb begin
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        prime_load  = 1'b0;
        if (!primed_q) begin
            if (prime_cnt_q == PRIME_LAST) begin
                primed_d   = 1'b1;
                prime_load = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        monitor_dbg_data_in_lane #(
            .DEBOUNCE (DEBOUNCE),
            .CW       (CW)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .prime_load (prime_load),
            .primed     (primed_q),
            .s_bit      (sdata[i]),
            .f_bit      (fdata[i]),
            .upd        (upd[i])
        );
    end

    // On an update the new filtered value equals sdata.
    always_comb begin
        case (EDGE_TYPE)
            0:       ev = upd & sdata;
            1:       ev = upd & ~sdata;
            default: ev = upd;
        endcase
    end

    always_comb begin
        irqmask_d = irqmask_q;
        w1c       = '0;
        if (wr_en && address == 2'd2) irqmask_d = wmask;
        if (wr_en && address == 2'd3) w1c = wmask;
        // Set has priority over a coincident clear.
        edgecap_d = (edgecap_q & ~w1c) | ev;
        irq_d     = |(edgecap_d & irqmask_d);
    end

    // Read mux uses pre-update register values.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            readdata_d = '0;
            case (address)
                2'd0:    readdata_d[WIDTH-1:0] = fdata;
                2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
                2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q      <= '0;
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_monitor_dbg_data_in.sv
// Bench for monitor_dbg_data_in: three instances (rising/falling/any edge) share
// stimulus; a history-based reference model is compared every cycle.

module tb_monitor_dbg_data_in;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic         clk = 1'b0;
    logic         reset_n, chipselect, read_n, write_n;
    logic [1:0]   address;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [2:0][31:0] rdata;
    logic [2:0]   irqs;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_pipe [$];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_f, m_mask;
    logic [W-1:0] m_ec [3];
    logic [W-1:0] m_rd [3];
    logic         m_irq [3];
    logic         m_primed;
    int           m_n;

    always #5 clk = ~clk;

    monitor_dbg_data_in #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DB), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[0]), .irq(irqs[0]));
    monitor_dbg_data_in #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DB), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[1]), .irq(irqs[1]));
    monitor_dbg_data_in #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DB), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[2]), .irq(irqs[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge of the model, using the inputs the DUTs sample at that edge.
    task automatic m_step();
        logic [W-1:0] s, flips, newf, clr;
        logic [W-1:0] ev [3];
        logic         all_diff, rsel, wsel;
        if (!reset_n) begin
            m_f = '0; m_mask = '0; m_primed = 1'b0; m_n = 0;
            m_hist.delete();
            m_pipe.delete();
            repeat (SYNC) m_pipe.push_back('0);
            for (int t = 0; t < 3; t++) begin
                m_ec[t] = '0; m_rd[t] = '0; m_irq[t] = 1'b0;
            end
            return;
        end
        s    = m_pipe[0];
        rsel = chipselect && !read_n;
        wsel = chipselect && !write_n;
        if (rsel) begin
            for (int t = 0; t < 3; t++) begin
                case (address)
                    2'd0:    m_rd[t] = m_f;
                    2'd2:    m_rd[t] = m_mask;
                    2'd3:    m_rd[t] = m_ec[t];
                    default: m_rd[t] = '0;
                endcase
            end
        end
        flips = '0;
        if (!m_primed) begin
            m_n++;
            if (m_n == SYNC + 1) begin
                m_f      = s;
                m_primed = 1'b1;
            end
        end else begin
            // A bit flips once the last DB synchronized samples all disagree with it.
            m_hist.push_back(s);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            if (m_hist.size() == DB) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][i] == m_f[i]) all_diff = 1'b0;
                    flips[i] = all_diff;
                end
            end
        end
        newf  = m_f ^ flips;
        ev[0] = flips & newf;
        ev[1] = flips & ~newf;
        ev[2] = flips;
        if (wsel && address == 2'd2) m_mask = writedata[W-1:0];
        clr = (wsel && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int t = 0; t < 3; t++) begin
            m_ec[t]  = (m_ec[t] & ~clr) | ev[t];
            m_irq[t] = |(m_ec[t] & m_mask);
        end
        m_f = newf;
        void'(m_pipe.pop_front());
        m_pipe.push_back(in_port);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("model_readdata_t%0d", t), rdata[t], {24'h0, m_rd[t]});
            chk($sformatf("model_irq_t%0d", t), {31'h0, irqs[t]}, {31'h0, m_irq[t]});
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic idle();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd0; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        tick();
        idle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 8'hFF;
        idle();
        ticks(3);
        chk("reset_readdata", rdata[0], 32'h0);
        chk("reset_irq", {31'h0, irqs[0]}, 32'h0);

        // Inputs high through reset must prime without capturing.
        reset_n = 1'b1;
        ticks(4);
        rd(2'd0); chk("primed_data", rdata[0], 32'hFF);
        rd(2'd3); chk("primed_ec_rise", rdata[0], 32'h0);
        chk("primed_ec_any", rdata[2], 32'h0);
        chk("primed_irq", {31'h0, irqs[0]}, 32'h0);

        in_port = 8'h00; ticks(8);
        rd(2'd3);
        chk("fall_ec_rise", rdata[0], 32'h00);
        chk("fall_ec_fall", rdata[1], 32'hFF);
        chk("fall_ec_any",  rdata[2], 32'hFF);
        wr(2'd3, 32'hFF);
        in_port = 8'hFF; ticks(8);
        rd(2'd3);
        chk("rise_ec_rise", rdata[0], 32'hFF);
        chk("rise_ec_fall", rdata[1], 32'h00);
        chk("rise_ec_any",  rdata[2], 32'hFF);
        wr(2'd3, 32'hFF);
        in_port = 8'h00; ticks(8);
        wr(2'd3, 32'hFF);

        // Bit 3 rise with mask 0x08: fdata updates on the 6th edge.
        wr(2'd2, 32'h08);
        in_port = 8'h08; ticks(5);
        chk("irq_before_edge", {31'h0, irqs[0]}, 32'h0);
        tick();
        chk("irq_after_edge", {31'h0, irqs[0]}, 32'h1);
        rd(2'd3); chk("ec_bit3", rdata[0], 32'h08);
        wr(2'd3, 32'h08);
        chk("irq_after_w1c", {31'h0, irqs[0]}, 32'h0);
        rd(2'd3); chk("ec_bit3_clr", rdata[0], 32'h00);
        in_port = 8'h00; ticks(8);
        wr(2'd3, 32'hFF);

        // Glitch shorter than DEBOUNCE is filtered; a DEBOUNCE-long pulse is not.
        in_port = 8'h01; ticks(3);
        in_port = 8'h00; ticks(8);
        rd(2'd0); chk("glitch_data", rdata[0], 32'h0);
        rd(2'd3); chk("glitch_ec", rdata[0], 32'h0);
        chk("glitch_ec_any", rdata[2], 32'h0);
        in_port = 8'h01; ticks(4);
        in_port = 8'h00; ticks(10);
        rd(2'd3); chk("pulse4_ec", rdata[0], 32'h01);
        wr(2'd3, 32'hFF);

        // W1C of bit 5 on the same edge its rising event lands: set wins.
        in_port = 8'h20; ticks(5);
        wr(2'd3, 32'h20);
        rd(2'd3); chk("set_beats_clr", rdata[0], 32'h20);
        wr(2'd3, 32'hFF);
        in_port = 8'h00; ticks(8);
        wr(2'd3, 32'hFF);

        // Mid-operation reset with live capture and mask.
        in_port = 8'hA5; ticks(8);
        wr(2'd2, 32'hFF);
        rd(2'd3); chk("ec_a5", rdata[0], 32'hA5);
        chk("irq_a5", {31'h0, irqs[0]}, 32'h1);
        reset_n = 1'b0;
        tick();
        chk("midreset_readdata", rdata[0], 32'h0);
        chk("midreset_irq", {31'h0, irqs[0]}, 32'h0);
        reset_n = 1'b1;
        ticks(4);
        rd(2'd3); chk("reprime_ec", rdata[0], 32'h0);
        rd(2'd0); chk("reprime_data", rdata[0], 32'hA5);
        rd(2'd1); chk("reserved_read", rdata[0], 32'h0);
        rd(2'd2); chk("mask_after_reset", rdata[0], 32'h0);

        // Randomized traffic: held values, glitches, bus ops, occasional reset.
        for (int it = 0; it < 1500; it++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0) in_port = 8'($urandom);
            else if (r == 1) in_port ^= 8'(1 << $urandom_range(0, 7));
            chipselect = ($urandom_range(0, 2) != 0);
            read_n     = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1;
        idle();
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
